regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Parametrised multi-read-port register file with an integrated scoreboard, for the CPU decode/writeback stages.
- Supports configurable data width, depth and read-port count.
- Optional hardwired-zero register 0 and write-to-read bypass.
- Per-register busy bits are set when an instruction issues and cleared at writeback; issue logic uses them for RAW hazard detection.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers; must be a power of two, ≥2.
- AW, $clog2(DEPTH), address width (derived).
- NRD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1: register 0 reads 0, is never written, and is never busy.
- BYPASS, 1, when 1: a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- we  in  1  writeback enable.
- wb_addr  in  AW  writeback address.
- wb_data  in  DW  writeback data.
- rd_addr  in  NRD*AW  packed read addresses; port k is bits [k*AW +: AW].
- rd_data  out  NRD*DW  packed read data (combinational).
- rd_busy  out  NRD  busy flag per read port (combinational).
- alloc_en  in  1  issue: mark destination busy.
- alloc_addr  in  AW  destination being allocated.
- flush  in  1  clear all busy bits (pipeline flush); data is kept.
- busy_cnt  out  AW+1  number of registers currently busy (registered).

Behaviour:
- Reset, when rst=1 at a clock edge:
  - all registers become 0; all busy bits 0; busy_cnt=0.
  - rst overrides we, alloc_en and flush in the same cycle.
  - After reset, every rd_data=0 and rd_busy=0.
- Write: when we=1, regs[wb_addr]<=wb_data at the edge; visible in storage from the next cycle.
  - If ZERO_REG=1 and wb_addr=0, the write is dropped.
- Read: rd_data[k] is combinational from rd_addr[k]; zero latency.
  - If ZERO_REG=1 and rd_addr[k]=0: rd_data[k]=0 and rd_busy[k]=0 unconditionally.
  - If BYPASS=1, we=1, wb_addr=rd_addr[k] and the write is not dropped: rd_data[k]=wb_data.
  - If BYPASS=0, the old stored value is returned until the next cycle.
- Busy bits:
  - busy[a] is set at the edge when alloc_en=1 and alloc_addr=a. Ignored for address 0 when ZERO_REG=1.
  - busy[a] is cleared at the edge when we=1 and wb_addr=a.
  - If alloc and writeback target the same address in the same cycle, alloc wins and busy stays/becomes 1 (a new producer supersedes).
  - flush=1 clears all busy bits, then a same-cycle alloc_en is applied. The result is exactly one busy bit if alloc is valid. A same-cycle we still writes data.
  - Allocating an already-busy register leaves it busy; no error or count change.
  - A writeback to a non-busy register is legal: data is written, busy stays 0.
- rd_busy[k]:
  - equals busy[rd_addr[k]], except when BYPASS=1 and a non-dropped writeback to that address occurs this cycle with no same-address alloc_en; then rd_busy[k]=0 (the operand is available via bypass).
  - Alloc in the current cycle does not affect rd_busy until the next cycle.
- busy_cnt: registered popcount of the next-state busy vector; updates on the same edge as the busy bits. Range 0..DEPTH (0..DEPTH-1 when ZERO_REG=1).
- Read ports are fully independent; any number may address the same register.
- All arithmetic is unsigned; addresses are always in range because DEPTH=2^AW.

Test Plan:
- Reset then read: after rst for one cycle, all 32 addresses on both ports return 0, rd_busy=0, busy_cnt=0. Pulse rst mid-sequence with regs[5]=0xDEADBEEF and busy[5]=1 → both cleared on the next edge.
- Write/read and zero register: write 0x12345678 to r7, then read r7 next cycle → 0x12345678. Write 0xFFFFFFFF to r0, then read r0 → 0, busy_cnt unchanged.
- Bypass: same cycle we=1 to r9 with 0xA5A5A5A5 and rd_addr[0]=9 → rd_data[0]=0xA5A5A5A5 combinationally. With BYPASS=0 → old value 0, then 0xA5A5A5A5 next cycle.
- Scoreboard: alloc r3 → next cycle rd_busy for r3=1, busy_cnt=1. Writeback r3 → rd_busy=0 in the same cycle (bypass), busy_cnt=0 next cycle.
- Collision: alloc r4 and writeback r4 in the same cycle → data written, r4 remains busy, busy_cnt=1. Alloc r0 → busy_cnt stays 0.
- Flush: alloc r1, r2 and r3 over three cycles (busy_cnt=3), then flush with alloc r6 in the same cycle → next cycle only r6 busy, busy_cnt=1, and r1–r3 data retained.

Source files
------------

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-read-port register file with per-register RAW busy scoreboard
module regfile_sb #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DW-1:0]     wb_data,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  input  logic              flush,
  output logic [AW:0]       busy_cnt
);

  logic [DW-1:0]    regs [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_nxt;
  logic             wr_ok;
  logic             alloc_ok;

  function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Register 0 is inert when hardwired: writes and allocations to it are dropped.
  always_comb begin
    wr_ok    = we && !((ZERO_REG != 0) && (wb_addr == '0));
    alloc_ok = alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0));
  end

  // Flush first, then writeback clears, then alloc sets so a new producer wins.
  always_comb begin
    busy_nxt = flush ? '0 : busy_q;
    if (we) begin
      busy_nxt[wb_addr] = 1'b0;
    end
    if (alloc_ok) begin
      busy_nxt[alloc_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy_q   <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_ok) begin
        regs[wb_addr] <= wb_data;
      end
      busy_q   <= busy_nxt;
      busy_cnt <= popcount(busy_nxt);
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] raddr;
    logic          is_zero;
    logic          hit;
    logic          realloc;

    always_comb begin
      raddr   = rd_addr[k*AW +: AW];
      is_zero = (ZERO_REG != 0) && (raddr == '0);
      hit     = (BYPASS != 0) && wr_ok && (wb_addr == raddr);
      realloc = alloc_en && (alloc_addr == raddr);

      rd_data[k*DW +: DW] = hit ? wb_data : regs[raddr];
      rd_busy[k]          = busy_q[raddr] && !(hit && !realloc);
      if (is_zero) begin
        rd_data[k*DW +: DW] = '0;
        rd_busy[k]          = 1'b0;
      end
    end
  end

endmodule
